// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI bus arbiter.
// Used by spi_rr_arbiter and spi_bus_arbiter.
package spi_arb_pkg;

    localparam int unsigned SPI_WORD_W  = 8;
    localparam int unsigned SCK_TOGGLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin winner select with a one-hot grant.
// The search starts at last+1 and wraps around.
// Build option SPI_ARB_PRIO0_EN: requester 0 wins whenever it requests, and
// such a win does not move the round-robin pointer (upd_ptr stays low).
module spi_rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               any,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               upd_ptr
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    // Pick the first requester after the pointer, wrapping around
    always_comb begin
        any      = 1'b0;
        onehot   = '0;
        idx      = '0;
        upd_ptr  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand     = (32'(last) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!any && req[cand_idx]) begin
                any     = 1'b1;
                onehot  = NUM_REQ'(1) << cand_idx;
                idx     = cand_idx;
                upd_ptr = 1'b1;
            end
        end
`ifdef SPI_ARB_PRIO0_EN
        if (req[0]) begin
            onehot  = NUM_REQ'(1);
            idx     = '0;
            upd_ptr = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// SPI mode-0 master shared by NUM_REQ requesters, one 8-bit full-duplex
// word per transaction, round-robin arbitration, one active-low select each.
// Build option SPI_ARB_PRIO0_EN gives requester 0 fixed top priority.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*SPI_WORD_W-1:0] tx_data_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic                          done_o,
    output logic [SPI_WORD_W-1:0]         rx_data_o,
    output logic                          busy_o,
    output logic                          sck_o,
    output logic                          mosi_o,
    input  logic                          miso_i,
    output logic [NUM_REQ-1:0]            ss_n_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
    localparam int unsigned TGL_W = $clog2(SCK_TOGGLES + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [TGL_W-1:0] TGL_LAST = TGL_W'(SCK_TOGGLES - 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      div_cnt;
    logic [TGL_W-1:0]      tgl_cnt;
    logic                  div_end;
    logic [IDX_W-1:0]      last_grant, cur_idx;
    logic                  cur_upd;
    logic [NUM_REQ-1:0]    cur_gnt, gnt_act;
    logic [SPI_WORD_W-1:0] tx_sh, rx_sh, rx_word;
    logic                  sck, miso_s1, miso_s2;
    logic                  arb_any, arb_upd;
    logic [NUM_REQ-1:0]    arb_onehot;
    logic [IDX_W-1:0]      arb_idx;

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (req_i),
        .last    (last_grant),
        .any     (arb_any),
        .onehot  (arb_onehot),
        .idx     (arb_idx),
        .upd_ptr (arb_upd)
    );

    assign div_end = (div_cnt == DIV_LAST);

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state: IDLE -> SETUP -> XFER (16 SCK toggles) -> HOLD -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (arb_any) state_nxt = ST_SETUP;
            ST_SETUP: if (div_end) state_nxt = ST_XFER;
            ST_XFER:  if (div_end && tgl_cnt == TGL_LAST) state_nxt = ST_HOLD;
            ST_HOLD:  if (div_end) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; grant and select only while SETUP/XFER
    always_comb begin
        gnt_act = ((state == ST_SETUP) || (state == ST_XFER)) ? cur_gnt : '0;
        gnt_o   = gnt_act;
        ss_n_o  = ~gnt_act;
        busy_o  = (state != ST_IDLE);
        done_o  = (state == ST_HOLD) && (div_cnt == '0);
    end

    assign sck_o     = sck;
    assign mosi_o    = tx_sh[SPI_WORD_W-1];
    assign rx_data_o = rx_word;

    // Datapath: divider, SCK generation, shift registers, pointer, MISO sync
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_cnt    <= '0;
            tgl_cnt    <= '0;
            sck        <= 1'b0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            rx_word    <= '0;
            cur_gnt    <= '0;
            cur_idx    <= '0;
            cur_upd    <= 1'b0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            miso_s1    <= 1'b0;
            miso_s2    <= 1'b0;
        end else begin
            miso_s1 <= miso_i;
            miso_s2 <= miso_s1;

            if (state == ST_IDLE || state_nxt != state || div_end) div_cnt <= '0;
            else                                                   div_cnt <= div_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        cur_gnt <= arb_onehot;
                        cur_idx <= arb_idx;
                        cur_upd <= arb_upd;
                        tx_sh   <= SPI_WORD_W'(tx_data_i >> (arb_idx * SPI_WORD_W));
                        rx_sh   <= '0;
                        tgl_cnt <= '0;
                        sck     <= 1'b0;
                    end
                end
                ST_XFER: begin
                    if (div_end) begin
                        sck     <= ~sck;
                        tgl_cnt <= tgl_cnt + 1'b1;
                        if (!sck)
                            rx_sh <= {rx_sh[SPI_WORD_W-2:0], miso_s2};
                        else if (tgl_cnt != TGL_LAST)
                            tx_sh <= {tx_sh[SPI_WORD_W-2:0], 1'b0};
                    end
                    if (state_nxt == ST_HOLD) begin
                        rx_word <= rx_sh;
                        if (cur_upd) last_grant <= cur_idx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed testbench for spi_bus_arbiter (NUM_REQ=4, CLK_DIV=2).
// Expected grants follow SPI_ARB_PRIO0_EN when the bench is built with it.
module tb_spi_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] tx;
    logic [3:0]  gnt;
    logic        done;
    logic [7:0]  rx_data;
    logic        busy;
    logic        sck;
    logic        mosi;
    logic        miso = 1'b0;
    logic [3:0]  ss_n;

    spi_bus_arbiter #(
        .NUM_REQ (4),
        .CLK_DIV (2)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .req_i     (req),
        .tx_data_i (tx),
        .gnt_o     (gnt),
        .done_o    (done),
        .rx_data_o (rx_data),
        .busy_o    (busy),
        .sck_o     (sck),
        .mosi_o    (mosi),
        .miso_i    (miso),
        .ss_n_o    (ss_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Mode-0 slave: loads its word at select, shifts after each SCK rise
    logic        sel;
    logic [7:0]  slave_rsp = 8'h00;
    logic [7:0]  sl_sh     = 8'h00;
    logic [7:0]  mosi_cap  = 8'h00;
    int unsigned nrise     = 0;
    assign sel = ~&ss_n;

    always @(posedge sck or posedge sel) begin
        if (sck) begin
            mosi_cap = {mosi_cap[6:0], mosi};
            nrise++;
            sl_sh = {sl_sh[6:0], 1'b0};
            miso  = sl_sh[7];
        end else begin
            sl_sh    = slave_rsp;
            miso     = sl_sh[7];
            mosi_cap = 8'h00;
            nrise    = 0;
        end
    end

    // Bus monitor: select/grant consistency, last grant seen, done pulses
    int unsigned viol = 0;
    int unsigned gnt_cycles = 0;
    int unsigned done_cnt = 0;
    logic [3:0]  seen_gnt = 4'h0;
    always @(negedge clk) begin
        if (!reset) begin
            if (ss_n !== ~gnt || $countones(~ss_n) > 1) viol++;
            if (gnt != 4'h0) begin
                seen_gnt = gnt;
                gnt_cycles++;
            end
            if (done) done_cnt++;
        end
    end

    typedef struct {
        logic [3:0]  req;
        logic [31:0] tx;
        logic [7:0]  rsp;
        int unsigned idx;
    } vec_t;

    vec_t vecs[9];

    task automatic apply_reset();
        req   = 4'h0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int unsigned k;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic run_xfer(input string tag, input logic [3:0] r, input logic [31:0] t,
                            input logic [7:0] rsp, input int unsigned idx, input bit drop_mid);
        int unsigned cyc;
        int unsigned d0;
        int unsigned g0;
        logic [3:0]  oh;
        logic [3:0]  ssx;
        logic [7:0]  exp_tx;
        oh        = 4'b0001 << idx;
        ssx       = ~oh;
        exp_tx    = t[8*idx +: 8];
        slave_rsp = rsp;
        d0        = done_cnt;
        @(posedge clk);
        #1;
        req = r;
        tx  = t;
        cyc = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check({tag, "_gnt"}, gnt, oh);
                check({tag, "_ss_n"}, ss_n, ssx);
            end
            if (drop_mid && nrise >= 3) req = 4'h0;
        end while (!done && cyc < 200);
        check({tag, "_latency"}, cyc, 35);
        check({tag, "_rx"}, rx_data, rsp);
        check({tag, "_mosi"}, mosi_cap, exp_tx);
        check({tag, "_bits"}, nrise, 8);
        check({tag, "_gnt_off"}, gnt, 4'h0);
        check({tag, "_ss_off"}, ss_n, 4'hF);
        req = 4'h0;
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 1'b0);
        if (drop_mid) begin
            g0 = gnt_cycles;
            repeat (40) @(negedge clk);
            check({tag, "_no_regrant"}, gnt_cycles - g0, 0);
            check({tag, "_done_once"}, done_cnt - d0, 1);
        end
        wait_idle(tag);
    endtask

    logic [3:0]  b2b_gnt[4];
    logic [7:0]  b2b_mosi[4];
    int unsigned cyc;

    initial begin
        req   = 4'h0;
        tx    = 32'h0;
        reset = 1'b1;

        vecs[0] = '{4'b0001, 32'h112233A5, 8'h3C, 0};
        vecs[1] = '{4'b1000, 32'h967E810F, 8'hF0, 3};
        vecs[2] = '{4'b1001, 32'h01FFFF80, 8'h81, 0};
`ifdef SPI_ARB_PRIO0_EN
        vecs[3] = '{4'b1001, 32'hE7000018, 8'h00, 0};
`else
        vecs[3] = '{4'b1001, 32'hE7000018, 8'h00, 3};
`endif
        vecs[4] = '{4'b0110, 32'h006CD200, 8'hFF, 1};
        vecs[5] = '{4'b0110, 32'h004BB400, 8'h55, 2};
        vecs[6] = '{4'b0010, 32'h0000AA00, 8'hAA, 1};
`ifdef SPI_ARB_PRIO0_EN
        vecs[7] = '{4'b0101, 32'h00990066, 8'h69, 0};
`else
        vecs[7] = '{4'b0101, 32'h00990066, 8'h69, 2};
`endif
        vecs[8] = '{4'b0100, 32'h003A0000, 8'h96, 2};

`ifdef SPI_ARB_PRIO0_EN
        b2b_gnt  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
        b2b_mosi = '{8'h11, 8'h11, 8'h11, 8'h11};
`else
        b2b_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        b2b_mosi = '{8'h11, 8'h22, 8'h33, 8'h44};
`endif

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_sck", sck, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_ss_n", ss_n, 4'hF);
        check("rst_gnt", gnt, 4'h0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rx", rx_data, 8'h00);
        reset = 1'b0;

        // Single transfers with round-robin pointer movement
        for (int i = 0; i < 9; i++)
            run_xfer($sformatf("v%0d", i), vecs[i].req, vecs[i].tx, vecs[i].rsp, vecs[i].idx, 1'b0);

        // Request dropped mid-transfer still completes exactly once
        run_xfer("drop", 4'b0100, 32'h00D40000, 8'hB7, 2, 1'b1);

        // Four requesters held continuously
        apply_reset();
        slave_rsp = 8'hC3;
        @(negedge clk);
        req = 4'hF;
        tx  = 32'h44332211;
        for (int n = 0; n < 4; n++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done && cyc < 200);
            check($sformatf("b2b%0d_spacing", n), cyc, (n == 0) ? 35 : 37);
            check($sformatf("b2b%0d_gnt", n), seen_gnt, b2b_gnt[n]);
            check($sformatf("b2b%0d_mosi", n), mosi_cap, b2b_mosi[n]);
            check($sformatf("b2b%0d_rx", n), rx_data, 8'hC3);
        end
        req = 4'h0;
        wait_idle("b2b");

        // Asynchronous reset at the 5th SCK toggle (3rd rising edge)
        slave_rsp = 8'h77;
        @(posedge clk);
        #1;
        req = 4'b0001;
        tx  = 32'h000000F0;
        cyc = 0;
        while (!(sel && nrise >= 3) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_reached", nrise, 3);
        #2;
        reset = 1'b1;
        req   = 4'h0;
        #1;
        check("mid_sck", sck, 1'b0);
        check("mid_mosi", mosi, 1'b0);
        check("mid_ss_n", ss_n, 4'hF);
        check("mid_gnt", gnt, 4'h0);
        check("mid_done", done, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_rx", rx_data, 8'h00);
        @(posedge clk);
        #1 reset = 1'b0;
        run_xfer("recover", 4'b0010, 32'h0000C500, 8'h5E, 1, 1'b0);

        check("ss_gnt_consistency", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
